alu_issue_ctrl: RTL and testbench

Instruction-issue and writeback controller that sits on the driving side of the 8-bit ALU.
- Accepts 16-bit register-to-register instructions over a valid/ready handshake.
- Reads operands from an internal 8x8 register file and drives the ALU operation, operand and shamt ports.
- Captures the ALU result and flags, then writes back to the register file and a 4-bit flag register.
- One instruction is in flight at a time; every accepted instruction takes exactly 3 cycles.

---
 rtl/alu_ctrl_pkg.sv | 58 +++++
 rtl/alu_issue_ctrl_if.sv | 12 +
 rtl/regfile_8x8.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Purpose : shared opcode encodings, instruction field positions and FSM/flag types for the ALU issue path.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package alu_ctrl_pkg;

    // Opcode encodings, shared with the ALU so the two sides cannot drift apart.
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LS  = 4'b0011;
    localparam logic [3:0] OP_SRS = 4'b0100;
    localparam logic [3:0] OP_URS = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_RRO = 4'b1000;
    localparam logic [3:0] OP_LRO = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1111;

    // Instruction word field positions.
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS_HI  = 8;
    localparam int RS_LO  = 6;
    localparam int RT_HI  = 5;
    localparam int RT_LO  = 3;
    localparam int SH_HI  = 2;
    localparam int SH_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    typedef struct packed {
        logic cr;
        logic ov;
        logic ng;
        logic zr;
    } flags_t;

    // True for opcodes that are executed by the ALU proper.
    function automatic logic op_is_alu(input logic [3:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_LS, OP_SRS, OP_URS,
                          OP_SUB, OP_SLT, OP_RRO, OP_LRO, OP_NOT};
    endfunction

    // Only the arithmetic ops produce meaningful carry/overflow.
    function automatic logic op_updates_cv(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Purpose : instruction issue handshake bundle (valid/ready + 16-bit instruction word).
// Latency : n/a (wires only).
// Backpr. : issuer holds instr_valid/instr until it sees instr_ready on the same edge.
// Ports   : master = instruction source, slave = issue controller.
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/regfile_8x8.sv
// Purpose : 8x8 register file, two combinational read ports for operand fetch plus a debug read port.
// Latency : reads combinational, write lands on the rising edge with we_i.
// Backpr. : none; always accepts a write.
// Ports   : clk/rst, ra/rb operand reads, dbg read, single write port (we_i, wa_i, wd_i).
module regfile_8x8 #(
    parameter int NREGS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ra_addr_i,
    output logic [7:0] ra_data_o,
    input  logic [2:0] rb_addr_i,
    output logic [7:0] rb_data_o,
    input  logic [2:0] dbg_addr_i,
    output logic [7:0] dbg_data_o,
    input  logic       we_i,
    input  logic [2:0] wa_i,
    input  logic [7:0] wd_i
);

    logic [7:0] mem_q [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign ra_data_o  = mem_q[ra_addr_i];
    assign rb_data_o  = mem_q[rb_addr_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Purpose : issues one reg-reg instruction to the external ALU, captures result/flags, writes back.
// Latency : 3 cycles per instruction (accept -> EXEC -> WB), done pulses in WB.
// Backpr. : instr_ready only in IDLE; instr_valid is ignored while an instruction is in flight.
// Ports   : clk/rst, issue (slave handshake), alu_* operand/result bus, done/illegal pulses,
//           flags {cr,ov,ng,zr}, dbg_addr/dbg_data register-file peek.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NREGS   = 8,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_ctrl_if.slave    issue,
    output logic [7:0]         alu_ina_o,
    output logic [7:0]         alu_inb_o,
    output logic [3:0]         alu_operation_o,
    output logic [SHAMT_W-1:0] alu_shamt_o,
    input  logic [7:0]         alu_out_i,
    input  logic               alu_cr_i,
    input  logic               alu_ov_i,
    input  logic               alu_ng_i,
    input  logic               alu_zr_i,
    output logic               done_o,
    output logic               illegal_o,
    output logic [3:0]         flags_o,
    input  logic [2:0]         dbg_addr_i,
    output logic [7:0]         dbg_data_o
);

    state_t               state_q, state_d;
    logic [3:0]           opc_q, opc_d;
    logic [2:0]           rd_q, rd_d;
    logic [7:0]           imm_q, imm_d;
    logic [7:0]           ina_q, ina_d;
    logic [7:0]           inb_q, inb_d;
    logic [3:0]           aluop_q, aluop_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic [7:0]           res_q, res_d;
    flags_t               res_flags_q, res_flags_d;
    flags_t               flags_q, flags_d;

    logic                 hs;
    logic                 is_illegal;
    logic [7:0]           rs_data, rt_data;
    logic                 rf_we;
    logic [7:0]           rf_wd;

    // Operands are read straight off the incoming word so they can be registered on the accept edge.
    regfile_8x8 #(.NREGS(NREGS)) u_rf (
        .clk        (clk),
        .rst        (rst),
        .ra_addr_i  (issue.instr[RS_HI:RS_LO]),
        .ra_data_o  (rs_data),
        .rb_addr_i  (issue.instr[RT_HI:RT_LO]),
        .rb_data_o  (rt_data),
        .dbg_addr_i (dbg_addr_i),
        .dbg_data_o (dbg_data_o),
        .we_i       (rf_we),
        .wa_i       (rd_q),
        .wd_i       (rf_wd)
    );

    assign issue.instr_ready = (state_q == IDLE);
    assign hs                = issue.instr_valid && issue.instr_ready;
    assign is_illegal        = !op_is_alu(opc_q) && (opc_q != OP_LDI);

    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        ina_d       = ina_q;
        inb_d       = inb_q;
        aluop_d     = aluop_q;
        shamt_d     = shamt_q;
        res_d       = res_q;
        res_flags_d = res_flags_q;
        flags_d     = flags_q;
        done_o      = 1'b0;
        illegal_o   = 1'b0;
        rf_we       = 1'b0;
        rf_wd       = res_q;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    opc_d   = issue.instr[OPC_HI:OPC_LO];
                    rd_d    = issue.instr[RD_HI:RD_LO];
                    imm_d   = issue.instr[IMM_HI:IMM_LO];
                    ina_d   = rs_data;
                    inb_d   = rt_data;
                    aluop_d = issue.instr[OPC_HI:OPC_LO];
                    shamt_d = SHAMT_W'(issue.instr[SH_HI:SH_LO]);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d       = alu_out_i;
                res_flags_d = '{cr: alu_cr_i, ov: alu_ov_i, ng: alu_ng_i, zr: alu_zr_i};
                state_d     = WB;
            end
            WB: begin
                done_o    = 1'b1;
                illegal_o = is_illegal;
                if (!is_illegal) begin
                    rf_we = 1'b1;
                    rf_wd = (opc_q == OP_LDI) ? imm_q : res_q;
                end
                // LDI and illegal ops leave the flag register untouched.
                if (op_is_alu(opc_q)) begin
                    flags_d.ng = res_flags_q.ng;
                    flags_d.zr = res_flags_q.zr;
                    if (op_updates_cv(opc_q)) begin
                        flags_d.cr = res_flags_q.cr;
                        flags_d.ov = res_flags_q.ov;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            opc_q       <= 4'h0;
            rd_q        <= 3'd0;
            imm_q       <= 8'h00;
            ina_q       <= 8'h00;
            inb_q       <= 8'h00;
            aluop_q     <= 4'h0;
            shamt_q     <= '0;
            res_q       <= 8'h00;
            res_flags_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            ina_q       <= ina_d;
            inb_q       <= inb_d;
            aluop_q     <= aluop_d;
            shamt_q     <= shamt_d;
            res_q       <= res_d;
            res_flags_q <= res_flags_d;
            flags_q     <= flags_d;
        end
    end

    assign alu_ina_o       = ina_q;
    assign alu_inb_o       = inb_q;
    assign alu_operation_o = aluop_q;
    assign alu_shamt_o     = shamt_q;
    assign flags_o         = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Purpose : directed self-checking bench for alu_issue_ctrl with a table-driven ALU response.
// Latency : expects accept, EXEC, WB on consecutive cycles.
// Backpr. : drives instr_valid and observes instr_ready on the issue interface.
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_ctrl_if bus ();

    logic [7:0] alu_ina, alu_inb, alu_out;
    logic [3:0] alu_op;
    logic [4:0] alu_shamt;
    logic       m_cr, m_ov, m_ng, m_zr;
    logic       done, illegal;
    logic [3:0] flags;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    alu_issue_ctrl #(.NREGS(8), .SHAMT_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .issue           (bus),
        .alu_ina_o       (alu_ina),
        .alu_inb_o       (alu_inb),
        .alu_operation_o (alu_op),
        .alu_shamt_o     (alu_shamt),
        .alu_out_i       (alu_out),
        .alu_cr_i        (m_cr),
        .alu_ov_i        (m_ov),
        .alu_ng_i        (m_ng),
        .alu_zr_i        (m_zr),
        .done_o          (done),
        .illegal_o       (illegal),
        .flags_o         (flags),
        .dbg_addr_i      (dbg_addr),
        .dbg_data_o      (dbg_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observations captured by run_instr for the caller to check.
    logic       iss_rdy, ex_done, ex_ill, wb_done, wb_ill;
    logic [7:0] ex_ina, ex_inb;
    logic [3:0] ex_op;
    logic [4:0] ex_sh;

    // Issue one word at a negedge, model the ALU response, end at the WB negedge.
    task automatic run_instr(input logic [15:0] w, input logic [7:0] res, input logic [3:0] fl);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        alu_out         = res;
        {m_cr, m_ov, m_ng, m_zr} = fl;
        iss_rdy = bus.instr_ready;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = 16'hFFFF;
        ex_done = done;
        ex_ill  = illegal;
        ex_op   = alu_op;
        ex_ina  = alu_ina;
        ex_inb  = alu_inb;
        ex_sh   = alu_shamt;
        @(negedge clk);
        wb_done = done;
        wb_ill  = illegal;
    endtask

    // Step past the WB edge so the writeback is visible; leaves the bench in the following IDLE cycle.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    logic [7:0] rv;
    int hs_cnt, done_cnt;

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        alu_out         = 8'h00;
        {m_cr, m_ov, m_ng, m_zr} = 4'b0000;
        dbg_addr        = 3'd0;

        #12;
        rst = 1'b0;
        #1;
        check("rst_ready",   bus.instr_ready, 1'b1);
        check("rst_done",    done,            1'b0);
        check("rst_illegal", illegal,         1'b0);
        check("rst_flags",   flags,           4'h0);
        check("rst_ina",     alu_ina,         8'h00);
        check("rst_inb",     alu_inb,         8'h00);
        check("rst_op",      alu_op,          4'h0);
        check("rst_shamt",   alu_shamt,       5'h00);

        // LDI r1,0x05 ; ALU garbage must be ignored.
        run_instr(16'hA205, 8'hEE, 4'b1111);
        check("ldi1_rdy",     iss_rdy, 1'b1);
        check("ldi1_ex_done", ex_done, 1'b0);
        check("ldi1_wb_done", wb_done, 1'b1);
        check("ldi1_wb_ill",  wb_ill,  1'b0);
        settle();
        peek(3'd1, rv); check("ldi1_r1", rv, 8'h05);

        // LDI r2,0x03
        run_instr(16'hA403, 8'hEE, 4'b1111);
        check("ldi2_wb_done", wb_done, 1'b1);
        settle();
        peek(3'd2, rv); check("ldi2_r2", rv, 8'h03);
        check("ldi_flags", flags, 4'b0000);

        // ADD r3,r1,r2 -> 0x08
        run_instr(16'h2650, 8'h08, 4'b0000);
        check("add_op",  ex_op,  4'b0010);
        check("add_ina", ex_ina, 8'h05);
        check("add_inb", ex_inb, 8'h03);
        settle();
        peek(3'd3, rv); check("add_r3", rv, 8'h08);
        check("add_flags", flags, 4'b0000);

        // SUB r4,r2,r2 -> 0x00, cr=1 zr=1
        run_instr(16'h6890, 8'h00, 4'b1001);
        check("sub_ina", ex_ina, 8'h03);
        settle();
        peek(3'd4, rv); check("sub_r4", rv, 8'h00);
        check("sub_flags", flags, 4'b1001);

        // AND r5,r1,r2 -> 0x01; cr held, zr cleared
        run_instr(16'h0A50, 8'h01, 4'b0000);
        settle();
        peek(3'd5, rv); check("and_r5", rv, 8'h01);
        check("and_flags", flags, 4'b1000);

        // LS r6,r1,3 -> 0x28; model raises ov, which must not reach the flag register
        run_instr(16'h3C43, 8'h28, 4'b0100);
        check("ls_op",    ex_op, 4'b0011);
        check("ls_shamt", ex_sh, 5'b00011);
        check("ls_ina",   ex_ina, 8'h05);
        settle();
        peek(3'd6, rv); check("ls_r6", rv, 8'h28);
        check("ls_flags", flags, 4'b1000);

        // Dependent ADD r7,r6,r6 issued in the cycle right after WB
        run_instr(16'h2FB0, 8'h50, 4'b0000);
        check("dep_rdy", iss_rdy, 1'b1);
        check("dep_ina", ex_ina, 8'h28);
        check("dep_inb", ex_inb, 8'h28);
        settle();
        peek(3'd7, rv); check("dep_r7", rv, 8'h50);
        check("dep_flags", flags, 4'b0000);

        // Illegal opcode 1100, rd=1
        run_instr(16'hC250, 8'hFF, 4'b1111);
        check("ill_ex_ill",  ex_ill,  1'b0);
        check("ill_wb_done", wb_done, 1'b1);
        check("ill_wb_ill",  wb_ill,  1'b1);
        settle();
        peek(3'd1, rv); check("ill_r1", rv, 8'h05);
        check("ill_flags",   flags,           4'b0000);
        check("ill_ready",   bus.instr_ready, 1'b1);
        check("ill_pulse",   illegal,         1'b0);

        // instr_valid held high for 6 cycles: two accepts, two done pulses
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h2650;
        alu_out         = 8'h08;
        {m_cr, m_ov, m_ng, m_zr} = 4'b0000;
        hs_cnt   = 0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.instr_ready) hs_cnt++;
            if (done) done_cnt++;
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        check("hold_accepts", 16'(hs_cnt),   16'd2);
        check("hold_dones",   16'(done_cnt), 16'd2);

        // Reset asserted during EXEC
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h2650;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("rstx_busy", bus.instr_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("rstx_ready_in", bus.instr_ready, 1'b1);
        check("rstx_done_in",  done,            1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstx_ready", bus.instr_ready, 1'b1);
        check("rstx_flags", flags,           4'b0000);
        for (int r = 0; r < 8; r++) begin
            peek(3'(r), rv);
            check($sformatf("rstx_r%0d", r), rv, 8'h00);
        end
        repeat (2) @(negedge clk);
        check("rstx_no_done", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
